// File: rtl/pipelined_adder_sub.sv
// Pipelined add/subtract unit: WIDTH bits split into STAGES equal slices with a
// registered carry between slices and one global valid/ready enable.
module pipelined_adder_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int SEG = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_param_check
        $error("pipelined_adder_sub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    // a/b carry the operands (b already inverted for subtract) until their slice is
    // consumed; sum collects finished slices so the full word leaves together.
    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } stage_t;

    stage_t       r_stage     [STAGES];
    stage_t       w_stage_in  [STAGES];
    stage_t       w_stage_out [STAGES];
    logic [SEG:0] w_slice     [STAGES];
    logic         w_adv;

    always_comb begin
        w_stage_in[0].valid = in_valid;
        w_stage_in[0].sub   = Sub;
        w_stage_in[0].carry = Cin ^ Sub;
        w_stage_in[0].a     = A;
        w_stage_in[0].b     = Sub ? ~B : B;
        w_stage_in[0].sum   = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_stage_in[k] = r_stage[k-1];
        end
    end

    // NOTE: every combinational output is assigned on every path (copy first, then
    // overwrite the slice) so no latch is inferred.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_slice[k] = {1'b0, w_stage_in[k].a[k*SEG +: SEG]}
                       + {1'b0, w_stage_in[k].b[k*SEG +: SEG]}
                       + {{SEG{1'b0}}, w_stage_in[k].carry};
            w_stage_out[k]                    = w_stage_in[k];
            w_stage_out[k].sum[k*SEG +: SEG]  = w_slice[k][SEG-1:0];
            w_stage_out[k].carry              = w_slice[k][SEG];
        end
    end

    assign w_adv = !r_stage[STAGES-1].valid || out_ready;

    // NOTE: data registers are reset along with the valid bits so Sum/Cout/Ovf read 0
    // during and right after reset; non-blocking assignments keep the shift race-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= w_stage_out[k];
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_stage[STAGES-1].valid;
    assign Sum       = r_stage[STAGES-1].sum;
    assign Cout      = r_stage[STAGES-1].carry ^ r_stage[STAGES-1].sub;
    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    assign Ovf       = r_stage[STAGES-1].a[WIDTH-1] ^ r_stage[STAGES-1].b[WIDTH-1]
                     ^ r_stage[STAGES-1].sum[WIDTH-1] ^ r_stage[STAGES-1].carry;

endmodule
